// File: rtl/lfsr_burst_serializer_pkg.sv
// rtl/lfsr_burst_serializer_pkg.sv - shared FSM encodings and default tap masks for the LFSR burst serializer
package lfsr_burst_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SER  = 2'd2
  } state_t;

  // Maximal-length feedback masks for common widths; other widths fall back to the top two bits.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      4:       return 32'h0000_000C;
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return 32'h3 << (width - 2);
    endcase
  endfunction

endpackage

// File: rtl/lfsr_burst_serializer_core.sv
// rtl/lfsr_burst_serializer_core.sv - Fibonacci LFSR register with seed load, step enable and next-state output
module lfsr_burst_serializer_core
  import lfsr_burst_serializer_pkg::*;
#(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] lfsr;

  assign nxt = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};

  // An all-zero state would lock up the XOR feedback, so a zero seed starts from 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= (seed == '0) ? WIDTH'(1) : seed;
    end else if (step) begin
      lfsr <= nxt;
    end
  end

endmodule

// File: rtl/lfsr_burst_serializer.sv
// rtl/lfsr_burst_serializer.sv - seeded LFSR burst generator that serializes each result word LSB-first
module lfsr_burst_serializer
  import lfsr_burst_serializer_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
  parameter int               SHIFT_CYCLES = 8,
  parameter int               CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [WIDTH-1:0] seed,
  output logic             out_bit,
  output logic             out_valid,
  output logic [WIDTH-1:0] word,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(SHIFT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SER_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] bitcnt, bitcnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] word_nxt;
  logic             done_nxt;
  logic             lfsr_load, lfsr_step;
  logic [WIDTH-1:0] lfsr_nxt;

  lfsr_burst_serializer_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed),
    .nxt   (lfsr_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      word   <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      bitcnt <= bitcnt_nxt;
      shreg  <= shreg_nxt;
      word   <= word_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    word_nxt   = word;
    done_nxt   = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        lfsr_step = 1'b1;
        // The final step's result goes straight to the shifter, so the word needs no extra cycle.
        if (cnt == RUN_LAST) begin
          shreg_nxt  = lfsr_nxt;
          word_nxt   = lfsr_nxt;
          bitcnt_nxt = '0;
          state_nxt  = ST_SER;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_SER: begin
        shreg_nxt = shreg >> 1;
        if (bitcnt == SER_LAST) begin
          if (cont) begin
            cnt_nxt   = '0;
            state_nxt = ST_RUN;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else begin
          bitcnt_nxt = bitcnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign out_valid = (state == ST_SER);
  assign out_bit   = out_valid & shreg[0];
  assign busy      = (state == ST_RUN) || (state == ST_SER);

endmodule

// File: tb/tb_lfsr_burst_serializer.sv
// tb/tb_lfsr_burst_serializer.sv - scoreboard bench for lfsr_burst_serializer (WIDTH=4, TAPS=4'hC)
module tb_lfsr_burst_serializer;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cont;
  logic [3:0] seed;
  logic       out_bit, out_valid, busy, done;
  logic [3:0] word;

  logic       c_start, c_cont;
  logic [3:0] c_seed;
  logic       c_out_bit, c_out_valid, c_busy, c_done;
  logic [3:0] c_word;

  int total = 0;
  int bad   = 0;

  logic q[$];
  logic cq[$];

  lfsr_burst_serializer #(
    .WIDTH(4), .TAPS(4'hC), .SHIFT_CYCLES(4), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .seed(seed),
    .out_bit(out_bit), .out_valid(out_valid), .word(word), .busy(busy), .done(done)
  );

  lfsr_burst_serializer #(
    .WIDTH(4), .TAPS(4'hC), .SHIFT_CYCLES(1), .CNT_W(6)
  ) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .cont(c_cont), .seed(c_seed),
    .out_bit(c_out_bit), .out_valid(c_out_valid), .word(c_word), .busy(c_busy), .done(c_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] step4(input logic [3:0] s);
    return {s[2:0], ^(s & 4'hC)};
  endfunction

  function automatic logic [3:0] model_word(input logic [3:0] sd, input int steps);
    logic [3:0] s;
    s = (sd == 4'h0) ? 4'h1 : sd;
    for (int i = 0; i < steps; i++) s = step4(s);
    return s;
  endfunction

  task automatic push_bits(input logic [3:0] w);
    for (int i = 0; i < 4; i++) q.push_back(w[i]);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) check("sb_underflow", 1, 0);
      else check("ser_bit", out_bit, q.pop_front());
    end else if (out_bit !== 1'b0) begin
      check("bit_idle", out_bit, 0);
    end
  end

  always @(negedge clk) begin
    if (c_out_valid === 1'b1) begin
      if (cq.size() == 0) check("c_sb_underflow", 1, 0);
      else check("c_ser_bit", c_out_bit, cq.pop_front());
    end else if (c_out_bit !== 1'b0) begin
      check("c_bit_idle", c_out_bit, 0);
    end
  end

  // One full non-continuous burst; inject pulses start with a foreign seed during RUN and SER.
  task automatic burst(input logic [3:0] sd, input bit inject);
    logic [3:0] w;
    w = model_word(sd, 4);
    push_bits(w);
    seed = sd;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("acc_busy", busy, 1);
    for (int i = 1; i <= 4; i++) begin
      if (inject && i == 2) begin start = 1'b1; seed = 4'hA; end
      if (inject && i == 3) start = 1'b0;
      tick;
      check("run_valid", out_valid, (i == 4));
    end
    check("word", word, w);
    for (int i = 1; i <= 4; i++) begin
      if (inject && i == 2) begin start = 1'b1; seed = 4'h6; end
      if (inject && i == 3) start = 1'b0;
      tick;
      check("ser_valid", out_valid, (i < 4));
      check("done", done, (i == 4));
      check("busy", busy, (i < 4));
    end
    tick;
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    logic [3:0] w;
    logic [3:0] m;
    logic [3:0] exp_w [1:16];

    rst = 1'b0; start = 1'b0; cont = 1'b0; seed = 4'h0;
    c_start = 1'b0; c_cont = 1'b0; c_seed = 4'h0;
    tick;
    tick;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_word", word, 0);
    check("rst_c_word", c_word, 0);
    rst = 1'b1;
    tick;

    burst(4'h1, 1'b0);
    check("t1_word", word, 4'h3);
    burst(4'h0, 1'b0);
    check("t2_word", word, 4'h3);
    burst(4'h1, 1'b1);
    check("t4_word", word, 4'h3);

    // Reset in the second SER cycle.
    w = model_word(4'h5, 4);
    push_bits(w);
    seed = 4'h5;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    check("t5_ser1", out_valid, 1);
    tick;
    check("t5_ser2", out_valid, 1);
    rst = 1'b0;
    tick;
    check("t5_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_word", word, 0);
    check("t5_done", done, 0);
    q.delete();
    rst = 1'b1;
    repeat (3) begin
      tick;
      check("t5_no_done", done, 0);
    end

    // Start held high across done: back-to-back bursts.
    w = model_word(4'h9, 4);
    push_bits(w);
    seed = 4'h9;
    start = 1'b1;
    tick;
    check("t6_busy", busy, 1);
    repeat (7) tick;
    check("t6_early_done", done, 0);
    tick;
    check("t6_done", done, 1);
    check("t6_idle", busy, 0);
    push_bits(w);
    tick;
    start = 1'b0;
    check("t6_b2b_busy", busy, 1);
    check("t6_b2b_done", done, 0);
    repeat (4) tick;
    check("t6_b2b_valid", out_valid, 1);
    check("t6_b2b_word", word, w);
    repeat (4) tick;
    check("t6_b2b_end", done, 1);
    tick;

    // Continuous mode, one LFSR step per word.
    m = 4'h1;
    for (int k = 1; k <= 16; k++) begin
      m = step4(m);
      exp_w[k] = m;
      for (int b = 0; b < 4; b++) cq.push_back(m[b]);
    end
    c_seed = 4'h1;
    c_cont = 1'b1;
    c_start = 1'b1;
    tick;
    c_start = 1'b0;
    check("c_busy_acc", c_busy, 1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) c_cont = 1'b0;
      tick;
      check("c_valid", c_out_valid, 1);
      check("c_word", c_word, exp_w[k]);
      if (k == 16) check("c_period", c_word, exp_w[1]);
      repeat (3) begin
        tick;
        check("c_valid_run", c_out_valid, 1);
      end
      tick;
      check("c_gap", c_out_valid, 0);
      check("c_done", c_done, (k == 16));
      check("c_busy", c_busy, (k < 16));
    end
    tick;

    check("sb_left", q.size(), 0);
    check("c_sb_left", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
